// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding and command byte constants.
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE} state_t;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET = 8'hFF;
    localparam logic [7:0] RESP_ACK = 8'hFA;
endpackage

// File: rtl/ps2_sync.sv
// ps2_sync: two-flop synchronizer for one PS/2 line plus falling-edge detect.
module ps2_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall
);
    logic meta, prev;
    // Idle PS/2 lines float high, so reset to 1 to avoid a spurious fall.
    always_ff @(posedge clk)
        if (rst) {meta, level, prev} <= 3'b111;
        else {meta, level, prev} <= {pin, meta, level};
    assign fall = prev & ~level;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with ACK check and watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_CYC = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);
    localparam int INHIBIT_CYC = CLK_FREQ_HZ / 1000000 * INHIBIT_US;
    localparam int MAX_CYC = TIMEOUT_CYC > INHIBIT_CYC ? TIMEOUT_CYC : INHIBIT_CYC;
    localparam int CW = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYC - 1);
    localparam logic [CW-1:0] INH_PRE = CW'(INHIBIT_CYC - 2);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    state_t state, nxt;
    logic [7:0] dat_q, dat_n;
    logic [3:0] idx_q, idx_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic par_q, par_n, ack_q, ack_n;
    logic clk_oe_n, data_oe_n, done_n, err_n;
    logic clk_lvl, clk_fall, dat_lvl, data_fall_unused;

    ps2_sync u_clk_sync (.clk(clk), .rst(rst), .pin(ps2_clk_in), .level(clk_lvl), .fall(clk_fall));
    ps2_sync u_dat_sync (.clk(clk), .rst(rst), .pin(ps2_data_in), .level(dat_lvl), .fall(data_fall_unused));

    assign tx_ready = state == IDLE;
    assign busy = state != IDLE;

    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            dat_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
            par_q <= 1'b0;
            ack_q <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done <= 1'b0;
            tx_err <= 1'b0;
        end else begin
            state <= nxt;
            dat_q <= dat_n;
            idx_q <= idx_n;
            cnt_q <= cnt_n;
            par_q <= par_n;
            ack_q <= ack_n;
            ps2_clk_oe <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            tx_done <= done_n;
            tx_err <= err_n;
        end

    always_comb begin
        nxt = state;
        dat_n = dat_q;
        idx_n = idx_q;
        par_n = par_q;
        ack_n = ack_q;
        clk_oe_n = ps2_clk_oe;
        data_oe_n = ps2_data_oe;
        done_n = 1'b0;
        err_n = 1'b0;
        case (state)
            IDLE: begin
                clk_oe_n = tx_valid;
                data_oe_n = 1'b0;
                if (tx_valid) begin
                    nxt = INHIBIT;
                    dat_n = tx_data;
                    par_n = ~^tx_data;
                end
            end
            INHIBIT: begin
                data_oe_n = cnt_q >= INH_PRE;
                if (cnt_q == INH_LAST) begin
                    nxt = REQ;
                    clk_oe_n = 1'b0;
                end
            end
            REQ:
                if (clk_fall) begin
                    nxt = BITS;
                    data_oe_n = ~dat_q[0];
                    idx_n = 4'd1;
                end
            BITS:
                if (clk_fall) begin
                    idx_n = idx_q + 4'd1;
                    data_oe_n = idx_q == 4'd9 ? 1'b0 : idx_q == 4'd8 ? ~par_q : ~dat_q[idx_q[2:0]];
                    nxt = idx_q == 4'd9 ? ACK : BITS;
                end
            ACK:
                if (clk_fall) begin
                    ack_n = ~dat_lvl;
                    nxt = WAIT_IDLE;
                end
            WAIT_IDLE:
                if (clk_lvl && dat_lvl) begin
                    nxt = IDLE;
                    done_n = ack_q;
                    err_n = ~ack_q;
                end
            default: nxt = IDLE;
        endcase
        // A device edge or a completed handshake on this cycle beats the watchdog.
        if (state inside {REQ, BITS, ACK, WAIT_IDLE} && !clk_fall && nxt == state && cnt_q == TO_LAST) begin
            nxt = IDLE;
            clk_oe_n = 1'b0;
            data_oe_n = 1'b0;
            err_n = 1'b1;
        end
        cnt_n = (nxt != state || state == IDLE || (clk_fall && state != INHIBIT)) ? '0 : cnt_q + CW'(1);
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-drain PS/2 device model clocking at 20-cycle half-period.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    logic clk = 1'b0, rst = 1'b1, tx_valid = 1'b0, dev_clk = 1'b1, dev_data = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic tx_ready, ps2_clk_in, ps2_data_in, clk_oe, data_oe, busy, tx_done, tx_err;
    int checks = 0, fails = 0;

    logic [10:0] got_bits;
    int got_inh;
    logic got_pulse, got_done, got_err, got_ready, got_single, proto_ok;

    always #5 clk = ~clk;
    assign ps2_clk_in = dev_clk & ~clk_oe;
    assign ps2_data_in = dev_data & ~data_oe;

    ps2_host_tx #(.CLK_FREQ_HZ(1000000), .INHIBIT_US(100), .TIMEOUT_CYC(2000)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(clk_oe),
        .ps2_data_oe(data_oe), .busy(busy), .tx_done(tx_done), .tx_err(tx_err)
    );

    // Device side: time the inhibit, record data_oe before each falling edge, answer on the 11th clock.
    task automatic device_xfer(input logic nack, input int falls);
        int n;
        proto_ok = 1'b1; got_pulse = 1'b0; got_done = 1'b0; got_err = 1'b0;
        got_ready = 1'b0; got_single = 1'b0; got_bits = '0; got_inh = 0; n = 0;
        while (!clk_oe && n < 200) begin @(negedge clk); n++; end
        if (!clk_oe) begin proto_ok = 1'b0; return; end
        while (clk_oe && got_inh < 1000) begin got_inh++; @(negedge clk); end
        repeat (5) @(negedge clk);
        for (int i = 0; i < falls; i++) begin
            got_bits[i] = data_oe;
            if (i == 10) dev_data = nack;
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
            dev_data = 1'b1;
            if (i < 10) repeat (20) @(negedge clk);
        end
        if (falls == 11)
            for (int k = 0; k < 60 && !got_pulse; k++) begin
                @(negedge clk);
                if (tx_done || tx_err) begin
                    got_pulse = 1'b1; got_done = tx_done; got_err = tx_err; got_ready = tx_ready;
                    @(negedge clk);
                    got_single = !tx_done && !tx_err;
                end
            end
    endtask

    task automatic send(input logic [7:0] b);
        tx_data = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 6;
        if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (clk_oe !== 1'b0) begin fails++; $display("FAIL reset_clk_oe: got %b want 0", clk_oe); end
        if (data_oe !== 1'b0) begin fails++; $display("FAIL reset_data_oe: got %b want 0", data_oe); end
        if (tx_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", tx_done); end
        if (tx_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", tx_err); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_send_ed;
        send(CMD_SET_LEDS);
        checks += 2;
        if (busy !== 1'b1) begin fails++; $display("FAIL ed_busy: got %b want 1", busy); end
        if (tx_ready !== 1'b0) begin fails++; $display("FAIL ed_ready_low: got %b want 0", tx_ready); end
        device_xfer(1'b0, 11);
        checks += 7;
        if (proto_ok !== 1'b1) begin fails++; $display("FAIL ed_proto: got %b want 1", proto_ok); end
        if (got_inh !== 100) begin fails++; $display("FAIL ed_inhibit: got %0d want 100", got_inh); end
        if (got_bits !== 11'b00000100101) begin fails++; $display("FAIL ed_bits: got %b want 00000100101", got_bits); end
        if (got_done !== 1'b1) begin fails++; $display("FAIL ed_done: got %b want 1", got_done); end
        if (got_err !== 1'b0) begin fails++; $display("FAIL ed_err: got %b want 0", got_err); end
        if (got_ready !== 1'b1) begin fails++; $display("FAIL ed_ready_at_pulse: got %b want 1", got_ready); end
        if (got_single !== 1'b1) begin fails++; $display("FAIL ed_pulse_width: got %b want 1", got_single); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_parity_zero;
        send(8'h00);
        device_xfer(1'b0, 11);
        checks += 3;
        if (got_bits !== 11'b00111111111) begin fails++; $display("FAIL zero_bits: got %b want 00111111111", got_bits); end
        if (got_done !== 1'b1) begin fails++; $display("FAIL zero_done: got %b want 1", got_done); end
        if (got_err !== 1'b0) begin fails++; $display("FAIL zero_err: got %b want 0", got_err); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_nack;
        send(CMD_SET_LEDS);
        device_xfer(1'b1, 11);
        checks += 4;
        if (got_err !== 1'b1) begin fails++; $display("FAIL nack_err: got %b want 1", got_err); end
        if (got_done !== 1'b0) begin fails++; $display("FAIL nack_done: got %b want 0", got_done); end
        if (got_ready !== 1'b1) begin fails++; $display("FAIL nack_ready: got %b want 1", got_ready); end
        if (got_single !== 1'b1) begin fails++; $display("FAIL nack_pulse_width: got %b want 1", got_single); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_timeout;
        int n, cyc;
        send(CMD_RESET);
        n = 0;
        while (clk_oe && n < 500) begin @(negedge clk); n++; end
        cyc = 0;
        while (!tx_err && cyc < 3000) begin @(negedge clk); cyc++; end
        checks += 5;
        if (cyc !== 2000) begin fails++; $display("FAIL timeout_cycles: got %0d want 2000", cyc); end
        if (clk_oe !== 1'b0) begin fails++; $display("FAIL timeout_clk_oe: got %b want 0", clk_oe); end
        if (data_oe !== 1'b0) begin fails++; $display("FAIL timeout_data_oe: got %b want 0", data_oe); end
        if (tx_ready !== 1'b1) begin fails++; $display("FAIL timeout_ready: got %b want 1", tx_ready); end
        if (tx_done !== 1'b0) begin fails++; $display("FAIL timeout_done: got %b want 0", tx_done); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int pulses;
        send(CMD_SET_LEDS);
        device_xfer(1'b0, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 5;
        if (clk_oe !== 1'b0) begin fails++; $display("FAIL midrst_clk_oe: got %b want 0", clk_oe); end
        if (data_oe !== 1'b0) begin fails++; $display("FAIL midrst_data_oe: got %b want 0", data_oe); end
        if (tx_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b want 1", tx_ready); end
        if (tx_done !== 1'b0) begin fails++; $display("FAIL midrst_done: got %b want 0", tx_done); end
        if (tx_err !== 1'b0) begin fails++; $display("FAIL midrst_err: got %b want 0", tx_err); end
        pulses = 0;
        repeat (50) begin @(negedge clk); pulses += int'(tx_done) + int'(tx_err); end
        checks++;
        if (pulses !== 0) begin fails++; $display("FAIL midrst_no_pulse: got %0d want 0", pulses); end
        send(CMD_RESET);
        device_xfer(1'b0, 11);
        checks += 2;
        if (got_bits !== 11'b00000000001) begin fails++; $display("FAIL ff_bits: got %b want 00000000001", got_bits); end
        if (got_done !== 1'b1) begin fails++; $display("FAIL ff_done: got %b want 1", got_done); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int extra;
        tx_data = CMD_SET_LEDS;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h55;
        device_xfer(1'b0, 11);
        tx_valid = 1'b0;
        checks += 2;
        if (got_bits !== 11'b00000100101) begin fails++; $display("FAIL b2b_first_bits: got %b want 00000100101", got_bits); end
        if (got_done !== 1'b1) begin fails++; $display("FAIL b2b_first_done: got %b want 1", got_done); end
        device_xfer(1'b0, 11);
        checks += 3;
        if (got_inh !== 100) begin fails++; $display("FAIL b2b_second_inhibit: got %0d want 100", got_inh); end
        if (got_bits !== 11'b00101010101) begin fails++; $display("FAIL b2b_second_bits: got %b want 00101010101", got_bits); end
        if (got_done !== 1'b1) begin fails++; $display("FAIL b2b_second_done: got %b want 1", got_done); end
        extra = 0;
        repeat (200) begin @(negedge clk); extra += int'(clk_oe); end
        checks++;
        if (extra !== 0) begin fails++; $display("FAIL b2b_no_third: got %0d want 0", extra); end
    endtask

    initial begin
        test_reset;
        test_send_ed;
        test_parity_zero;
        test_nack;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the game logic to the keyboard.
- Complements the existing PS/2 receive path that shares the same two open-drain lines.
- Handles the full host request sequence: clock inhibit, start bit, 8 data bits, odd parity, stop, device ACK, and a watchdog timeout.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency.
- INHIBIT_US, 100, ps2_clk hold-low time in microseconds; INHIBIT_CYC = CLK_FREQ_HZ/1000000*INHIBIT_US.
- TIMEOUT_CYC, 750000, max system cycles between device clock falling edges (15 ms at 50 MHz).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  request; accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  raw PS/2 clock line (asynchronous).
- ps2_data_in  in  1  raw PS/2 data line (asynchronous).
- ps2_clk_oe  out  1  1 = pull clock line low; 0 = release.
- ps2_data_oe  out  1  1 = pull data line low; 0 = release.
- busy  out  1  high in any state other than IDLE; the receive path ignores the line while busy.
- tx_done  out  1  one-cycle pulse: byte sent and ACKed.
- tx_err  out  1  one-cycle pulse: NACK or timeout.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE; tx_ready=1; busy=0; ps2_clk_oe=0; ps2_data_oe=0; tx_done=0; tx_err=0; counters 0.
- Reset mid-transfer: lines are released on the next edge; no done/err pulse.
- Input sync: ps2_clk_in and ps2_data_in each pass through 2 flops.
- Falling-edge detect: fall = sync_prev & ~sync_cur, on the synchronized clock.
- Edge latency: 3 cycles from the pin to fall.
- Accept: on accept, latch tx_data and par = ~^tx_data (odd parity). Enter INHIBIT.
- tx_valid outside IDLE is ignored; no queueing.
- INHIBIT: ps2_clk_oe=1 for INHIBIT_CYC cycles. ps2_data_oe=1 on the last cycle. Then go to REQ.
- REQ: ps2_clk_oe=0, ps2_data_oe=1 (start bit 0). On fall, drive bit0 (data_oe = ~bit), set idx=1, go to BITS.
- BITS: on each fall, drive by idx:
  - idx 1..7: data bit idx.
  - idx 8: par.
  - idx 9: stop (data_oe=0).
  - idx increments each fall; after stop is driven, go to ACK.
- Line values change only on fall and are held between edges.
- ACK: on fall, sample synced data. 0 means ACK_OK; 1 means NACK. Go to WAIT_IDLE.
- WAIT_IDLE: wait until synced clock=1 and data=1. Then pulse tx_done (ACK_OK) or tx_err (NACK) for 1 cycle. Return to IDLE, where tx_ready=1 on the same cycle as the pulse.
- Watchdog:
  - Counter clears on every fall and on state entry; active in REQ, BITS, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYC: release both lines, pulse tx_err, go to IDLE.
- Simultaneous fall and timeout on the same cycle: fall wins.
- Outputs are registered; ps2_*_oe never glitch.

Decomposition:
- Shared package ps2_pkg:
  - State enum: IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE.
  - Command constants: CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, RESP_ACK=8'hFA.
- Sub-module ps2_sync: 2-flop synchronizer plus falling-edge detect, one instance per line. The receive path uses it as well.

Test Plan (CLK_FREQ_HZ=1000000, INHIBIT_US=100, TIMEOUT_CYC=2000; device model clocks at 20-cycle half-period):
- Send 0xED, device ACKs:
  - clk_oe high for exactly 100 cycles.
  - data_oe per falling edge: 1 (start), then 0,1,0,0,1,0,0,0 (~bits, LSB first), 0 (parity=1), 0 (stop).
  - Device pulls data low on the 11th clock → tx_done=1 for one cycle, tx_err=0.
- Send 0x00 → parity bit 1 (data_oe=0 on parity slot); ACK → tx_done.
- Device holds data high on ACK clock → tx_err pulse, no tx_done, tx_ready back to 1.
- Device never clocks after REQ → tx_err exactly 2000 cycles after REQ entry; both oe=0.
- rst asserted during bit 4:
  - Next cycle both oe=0, tx_ready=1, no pulses.
  - New 0xFF afterwards completes with tx_done.
- tx_valid held high with 0x55 during a 0xED transfer → only 0xED is transmitted; 0x55 is accepted only after tx_ready returns.
